// File: rtl/ttt_game_ctrl.sv
// Tic-Tac-Toe game sequencer: clears the board, accepts legal moves,
// alternates players, waits for win-detect, keeps scores and picks the
// starting player of the next game. All outputs come straight from flops.
`timescale 1ns/1ps
module ttt_game_ctrl #(
  parameter int SCORE_W   = 4,
  parameter int CHECK_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               confirm_in,
  input  logic [3:0]         cursor_addr,
  input  logic [1:0]         cell_rd,
  input  logic [9:0]         gameover,
  output logic [3:0]         brd_waddr,
  output logic [1:0]         brd_wdata,
  output logic               brd_wen,
  output logic [1:0]         active_player,
  output logic               illegal_o,
  output logic               game_over_o,
  output logic               busy_o,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2
);

  localparam int CW = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;
  localparam logic [CW-1:0] CHK_LAST = CW'(CHECK_LAT - 1);
  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P2 = 2'b10;

  typedef enum logic [2:0] {S_CLEAR, S_TURN, S_WRITE, S_CHECK, S_OVER} state_t;

  state_t             state_q, state_d;
  logic [1:0]         clr_row_q, clr_row_d;
  logic [1:0]         clr_col_q, clr_col_d;
  logic               arm_q, arm_d;
  logic [CW-1:0]      chk_cnt_q, chk_cnt_d;
  logic [3:0]         move_cnt_q, move_cnt_d;
  logic [1:0]         active_q, active_d;
  logic [1:0]         next_first_q, next_first_d;
  logic [1:0]         cur_first_q, cur_first_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic               wen_q, wen_d;
  logic [3:0]         waddr_q, waddr_d;
  logic [1:0]         wdata_q, wdata_d;
  logic               illegal_q, illegal_d;
  logic               over_q, over_d;
  logic               busy_q, busy_d;

  logic take;
  logic legal;
  logic win;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A confirm only counts once TURN has been held for at least one cycle
  assign take  = (state_q == S_TURN) && arm_q && confirm_in;
  assign legal = (cell_rd == 2'b00) && (cursor_addr[3:2] != 2'b11) &&
                 (cursor_addr[1:0] != 2'b11);
  assign win   = gameover[9] && (|gameover[7:0]);

  // State and output registers; scores and first-player choice clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      clr_row_q    <= 2'd0;
      clr_col_q    <= 2'd0;
      arm_q        <= 1'b0;
      chk_cnt_q    <= '0;
      move_cnt_q   <= 4'd0;
      active_q     <= P1;
      next_first_q <= P1;
      cur_first_q  <= P1;
      score1_q     <= '0;
      score2_q     <= '0;
      wen_q        <= 1'b0;
      waddr_q      <= 4'd0;
      wdata_q      <= 2'd0;
      illegal_q    <= 1'b0;
      over_q       <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_row_q    <= clr_row_d;
      clr_col_q    <= clr_col_d;
      arm_q        <= arm_d;
      chk_cnt_q    <= chk_cnt_d;
      move_cnt_q   <= move_cnt_d;
      active_q     <= active_d;
      next_first_q <= next_first_d;
      cur_first_q  <= cur_first_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      illegal_q    <= illegal_d;
      over_q       <= over_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic: sweep counter, move/check sequencing, scoring
  always_comb begin
    state_d      = state_q;
    clr_row_d    = clr_row_q;
    clr_col_d    = clr_col_q;
    arm_d        = (state_q == S_TURN);
    chk_cnt_d    = chk_cnt_q;
    move_cnt_d   = move_cnt_q;
    active_d     = active_q;
    next_first_d = next_first_q;
    cur_first_d  = cur_first_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    case (state_q)
      S_CLEAR: begin
        if (clr_col_q == 2'd2) begin
          clr_col_d = 2'd0;
          if (clr_row_q == 2'd2) begin
            clr_row_d   = 2'd0;
            move_cnt_d  = 4'd0;
            active_d    = next_first_q;
            cur_first_d = next_first_q;
            state_d     = S_TURN;
          end else begin
            clr_row_d = clr_row_q + 2'd1;
          end
        end else begin
          clr_col_d = clr_col_q + 2'd1;
        end
      end
      S_TURN: begin
        if (take && legal) state_d = S_WRITE;
      end
      S_WRITE: begin
        move_cnt_d = move_cnt_q + 4'd1;
        active_d   = ~active_q;
        chk_cnt_d  = '0;
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        if (chk_cnt_q == CHK_LAST) begin
          if (win) begin
            if (gameover[8]) begin
              score2_d     = sat_inc(score2_q);
              next_first_d = P1;
            end else begin
              score1_d     = sat_inc(score1_q);
              next_first_d = P2;
            end
            state_d = S_OVER;
          end else if (gameover[9] || (move_cnt_q == 4'd9)) begin
            next_first_d = ~cur_first_q;
            state_d      = S_OVER;
          end else begin
            state_d = S_TURN;
          end
        end else begin
          chk_cnt_d = chk_cnt_q + 1'b1;
        end
      end
      S_OVER: begin
        if (confirm_in) begin
          clr_row_d = 2'd0;
          clr_col_d = 2'd0;
          state_d   = S_CLEAR;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Output logic: the write-port flops double as the latched move, so the
  // board write lands the cycle after the accepted confirm
  always_comb begin
    wen_d     = 1'b0;
    waddr_d   = 4'd0;
    wdata_d   = 2'd0;
    illegal_d = take && !legal;
    if (state_q == S_CLEAR) begin
      wen_d   = 1'b1;
      waddr_d = {clr_row_q, clr_col_q};
    end else if (take && legal) begin
      wen_d   = 1'b1;
      waddr_d = cursor_addr;
      wdata_d = active_q;
    end
    busy_d = (state_d == S_CLEAR) || (state_d == S_WRITE) || (state_d == S_CHECK);
    over_d = (state_d == S_OVER);
  end

  assign brd_wen       = wen_q;
  assign brd_waddr     = waddr_q;
  assign brd_wdata     = wdata_q;
  assign active_player = active_q;
  assign illegal_o     = illegal_q;
  assign game_over_o   = over_q;
  assign busy_o        = busy_q;
  assign score1        = score1_q;
  assign score2        = score2_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: clear sweep, legal/illegal moves,
// wins, draws, score saturation and reset in the middle of a sweep.
`timescale 1ns/1ps
module tb_ttt_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       confirm_in = 1'b0;
  logic [3:0] cursor_addr = 4'd0;
  logic [1:0] cell_rd = 2'd0;
  logic [9:0] gameover = 10'd0;
  logic [3:0] brd_waddr;
  logic [1:0] brd_wdata;
  logic       brd_wen;
  logic [1:0] active_player;
  logic       illegal_o;
  logic       game_over_o;
  logic       busy_o;
  logic [3:0] score1;
  logic [3:0] score2;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_act;
  logic [1:0] game_first;
  int exp_s1 = 0;
  int exp_s2 = 0;

  ttt_game_ctrl #(.SCORE_W(4), .CHECK_LAT(2)) dut (
    .clk(clk), .rst(rst), .confirm_in(confirm_in), .cursor_addr(cursor_addr),
    .cell_rd(cell_rd), .gameover(gameover), .brd_waddr(brd_waddr),
    .brd_wdata(brd_wdata), .brd_wen(brd_wen), .active_player(active_player),
    .illegal_o(illegal_o), .game_over_o(game_over_o), .busy_o(busy_o),
    .score1(score1), .score2(score2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT in CLEAR index 0; returns armed in TURN
  task automatic clear_sweep(input logic [1:0] first);
    int a[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("clr_wen", brd_wen, 1);
      chk("clr_addr", brd_waddr, a[i]);
      chk("clr_data", brd_wdata, 0);
      if (i < 8) chk("clr_busy", busy_o, 1);
    end
    chk("turn_busy", busy_o, 0);
    chk("turn_player", active_player, first);
    exp_act    = first;
    game_first = first;
    @(negedge clk);
    chk("turn_wen", brd_wen, 0);
    chk("turn_waddr", brd_waddr, 0);
  endtask

  task automatic do_move(input logic [3:0] a, input logic [9:0] go, input bit exp_over);
    gameover    = go;
    cursor_addr = a;
    cell_rd     = 2'b00;
    confirm_in  = 1'b1;
    @(negedge clk);
    confirm_in = 1'b0;
    chk("mv_wen", brd_wen, 1);
    chk("mv_waddr", brd_waddr, a);
    chk("mv_wdata", brd_wdata, exp_act);
    chk("mv_busy", busy_o, 1);
    @(negedge clk);
    exp_act = ~exp_act;
    chk("mv_wen_off", brd_wen, 0);
    chk("mv_toggle", active_player, exp_act);
    @(negedge clk);
    chk("chk_busy", busy_o, 1);
    @(negedge clk);
    chk("after_over", game_over_o, exp_over);
    chk("after_busy", busy_o, 0);
    gameover = 10'd0;
    @(negedge clk);
  endtask

  task automatic bad_move(input logic [3:0] a, input logic [1:0] c);
    cursor_addr = a;
    cell_rd     = c;
    confirm_in  = 1'b1;
    @(negedge clk);
    confirm_in = 1'b0;
    cell_rd    = 2'b00;
    chk("ill_wen", brd_wen, 0);
    chk("ill_pulse", illegal_o, 1);
    chk("ill_player", active_player, exp_act);
    @(negedge clk);
    chk("ill_end", illegal_o, 0);
    chk("ill_busy", busy_o, 0);
  endtask

  task automatic new_game(input logic [1:0] first);
    chk("ng_over", game_over_o, 1);
    confirm_in = 1'b1;
    @(negedge clk);
    confirm_in = 1'b0;
    chk("ng_busy", busy_o, 1);
    chk("ng_over_off", game_over_o, 0);
    chk("ng_illegal", illegal_o, 0);
    clear_sweep(first);
  endtask

  task automatic check_scores();
    chk("score1", score1, exp_s1);
    chk("score2", score2, exp_s2);
  endtask

  // One-move game whose outcome comes entirely from the gameover vector
  task automatic short_game(input logic [9:0] go);
    logic [1:0] nf;
    do_move(4'd0, go, 1'b1);
    if (go[9] && (|go[7:0])) begin
      if (go[8]) begin
        if (exp_s2 < 15) exp_s2++;
        nf = 2'b01;
      end else begin
        if (exp_s1 < 15) exp_s1++;
        nf = 2'b10;
      end
    end else begin
      nf = ~game_first;
    end
    check_scores();
    new_game(nf);
  endtask

  initial begin
    int a9[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wen", brd_wen, 0);
    chk("rst_busy", busy_o, 1);
    chk("rst_player", active_player, 2'b01);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_over", game_over_o, 0);
    check_scores();
    rst = 1'b0;
    clear_sweep(2'b01);

    // legal move then rejected confirms
    do_move(4'd5, 10'd0, 1'b0);
    bad_move(4'd6, 2'b01);
    bad_move(4'd3, 2'b00);
    bad_move(4'd12, 2'b00);

    // P1 completes the middle row
    do_move(4'd0, 10'd0, 1'b0);
    do_move(4'd4, 10'd0, 1'b0);
    do_move(4'd1, 10'd0, 1'b0);
    do_move(4'd6, 10'b10_0000_0010, 1'b1);
    exp_s1 = 1;
    check_scores();
    new_game(2'b10);

    // full board without a winner
    for (int i = 0; i < 9; i++) do_move(4'(a9[i]), 10'd0, i == 8);
    check_scores();
    new_game(~game_first);

    // P2 win, line-less game-over draw, then P1 wins up to saturation
    short_game(10'b11_0000_0001);
    short_game(10'b10_0000_0000);
    for (int i = 0; i < 15; i++) short_game(10'b10_0100_0000);
    chk("sat_score1", score1, 15);

    // reset in the middle of the next sweep
    do_move(4'd8, 10'b10_0000_1000, 1'b1);
    chk("sat_hold", score1, 15);
    confirm_in = 1'b1;
    @(negedge clk);
    confirm_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pre_rst_addr", brd_waddr, a9[i]);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_wen", brd_wen, 0);
    chk("mid_rst_s1", score1, 0);
    chk("mid_rst_busy", busy_o, 1);
    exp_s1 = 0;
    exp_s2 = 0;
    @(negedge clk);
    rst = 1'b0;
    clear_sweep(2'b01);
    do_move(4'd9, 10'b10_0000_0000, 1'b1);
    check_scores();
    new_game(2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
